// File: rtl/det_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : det_event_monitor
// Purpose  : Counts 1011-detector pulses overall and per fixed window, and
//            raises a sticky alarm when a window's count reaches THRESH.
// Revision : 1.0 - initial release
// ============================================================================
module det_event_monitor #(
    parameter int CNT_W      = 8,
    parameter int WIN_CYCLES = 32,
    parameter int THRESH     = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             det_in,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] last_win,
    output logic             win_valid,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int               CYC_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ALARM = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             valid_q, valid_d;
    logic             alarm_q, alarm_d;

    logic [CNT_W-1:0] total_inc;
    logic [CNT_W-1:0] win_closing;

    always_comb begin
        total_inc   = (total_q == CNT_MAX) ? total_q : total_q + CNT_W'(1);
        // Window count including this edge's detection; used both as the
        // carried count and as the closing count for the threshold test.
        win_closing = (det_in && (win_q != CNT_MAX)) ? win_q + CNT_W'(1) : win_q;

        state_d = state_q;
        total_d = total_q;
        win_d   = win_q;
        last_d  = last_q;
        cyc_d   = cyc_q;
        valid_d = 1'b0;

        if (clr) begin
            total_d = '0;
            win_d   = '0;
            last_d  = '0;
            cyc_d   = '0;
            case (state_q)
                ST_ALARM: state_d = en ? ST_RUN : ST_IDLE;
                ST_RUN:   state_d = en ? ST_RUN : ST_IDLE;
                default:  state_d = en ? ST_RUN : ST_IDLE;
            endcase
        end else if (!en) begin
            // Disable restarts the window; ALARM stays latched until cleared.
            cyc_d = '0;
            win_d = '0;
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
        end else begin
            if (det_in) begin
                total_d = total_inc;
            end
            if (cyc_q == CYC_LAST) begin
                last_d  = win_closing;
                win_d   = '0;
                cyc_d   = '0;
                valid_d = 1'b1;
                if (win_closing >= THRESH_V) begin
                    state_d = ST_ALARM;
                end
            end else begin
                win_d = win_closing;
                cyc_d = cyc_q + CYC_W'(1);
            end
        end

        alarm_d = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            win_q   <= '0;
            last_q  <= '0;
            cyc_q   <= '0;
            valid_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            win_q   <= win_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            valid_q <= valid_d;
            alarm_q <= alarm_d;
        end
    end

    assign total_cnt = total_q;
    assign win_cnt   = win_q;
    assign last_win  = last_q;
    assign win_valid = valid_q;
    assign alarm     = alarm_q;
    assign state     = state_q;

endmodule
`default_nettype wire
